// File: rtl/locked_data_memory.sv
// locked_data_memory: RV32I data-side word memory with a self-clearing init
// sweep, one-cycle registered responses, a sticky write lock over a protected
// address window, and a mailbox register mirroring stores to one word.
module locked_data_memory #(
  parameter int unsigned         DEPTH        = 256,
  parameter int unsigned         ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]   PROT_BASE    = 'h0000_0000,
  parameter logic [ADDR_W-1:0]   PROT_LIMIT   = 'h0000_0080,
  parameter logic [ADDR_W-1:0]   MAILBOX_ADDR = 'h0000_0064
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_width,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              lock_set,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              locked,
  output logic [31:0]       mailbox
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] W_SB = 3'b000;
  localparam logic [2:0] W_SH = 3'b001;
  localparam logic [2:0] W_UB = 3'b100;
  localparam logic [2:0] W_UH = 3'b101;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic [IDX_W-1:0]  init_cnt_nxt;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic [ADDR_W-3:0] word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic              out_of_range;
  logic              misaligned;
  logic              bad_width;
  logic              bad_store_width;
  logic              prot_hit;
  logic              lock_fault;
  logic              fault;
  logic              mem_we;
  logic              mailbox_hit;

  logic [31:0]       cur_word;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [3:0]        byte_en;
  logic [31:0]       store_lanes;
  logic [31:0]       store_word;

  // State register and init sweep counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Next-state: INIT clears one word per cycle for DEPTH cycles, then RUN accepts every cycle.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    req_ready    = 1'b0;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt    = ST_RUN;
          init_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        req_ready = 1'b1;
      end
    endcase
  end

  // Request decode: fault classification, load extraction and store merge.
  always_comb begin
    accept          = req_valid & req_ready;
    word_addr       = req_addr[ADDR_W-1:2];
    word_idx        = word_addr[IDX_W-1:0];
    out_of_range    = ({2'b00, word_addr} >= ADDR_W'(DEPTH));
    misaligned      = ((req_width[1:0] == 2'b01) & req_addr[0]) |
                      ((req_width[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    bad_width       = req_width inside {3'b011, 3'b110, 3'b111};
    bad_store_width = req_write & req_width[2];
    // Offset compare keeps the window test a single unsigned comparison.
    prot_hit        = (req_addr - PROT_BASE) < (PROT_LIMIT - PROT_BASE);
    lock_fault      = req_write & locked & prot_hit;
    fault           = out_of_range | misaligned | bad_width | bad_store_width | lock_fault;
    mem_we          = accept & req_write & ~fault;
    mailbox_hit     = (word_addr == MAILBOX_ADDR[ADDR_W-1:2]);

    cur_word  = mem[word_idx];
    load_byte = cur_word[{req_addr[1:0], 3'b000} +: 8];
    load_half = req_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (req_width)
      W_SB:    load_data = {{24{load_byte[7]}}, load_byte};
      W_UB:    load_data = {24'h00_0000, load_byte};
      W_SH:    load_data = {{16{load_half[15]}}, load_half};
      W_UH:    load_data = {16'h0000, load_half};
      default: load_data = cur_word;
    endcase

    byte_en     = 4'b1111;
    store_lanes = req_wdata;
    case (req_width[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << req_addr[1:0];
        store_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        store_lanes = req_wdata;
      end
    endcase
    store_word = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        store_word[8*b +: 8] = store_lanes[8*b +: 8];
      end
    end
  end

  // Memory array: cleared by the init sweep, then written by non-faulting stores.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= '0;
    end else if (mem_we) begin
      mem[word_idx] <= store_word;
    end
  end

  // Sticky lock; only reset clears it. Stores this cycle still see the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked <= 1'b0;
    end else if (lock_set) begin
      locked <= 1'b1;
    end
  end

  // Registered response: one pulse per accepted request, data zero on stores and faults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_fault <= accept & fault;
      rsp_rdata <= (accept & ~req_write & ~fault) ? load_data : '0;
    end
  end

  // Mailbox mirrors the merged word of any successful store to its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mailbox <= '0;
    end else if (mem_we & mailbox_hit) begin
      mailbox <= store_word;
    end
  end

endmodule

// File: tb/tb_locked_data_memory.sv
// Self-checking bench for locked_data_memory: byte-array reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_locked_data_memory;

  localparam int unsigned DEPTH      = 256;
  localparam logic [31:0] PROT_LIMIT = 32'h0000_0080;
  localparam logic [31:0] MBOX       = 32'h0000_0064;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_width = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        lock_set = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        locked;
  logic [31:0] mailbox;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model state (byte addressed)
  logic [7:0]  mb [4*DEPTH];
  int          m_init_left = DEPTH;
  bit          m_locked = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_fault = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_mailbox = '0;

  locked_data_memory #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .PROT_BASE(32'h0000_0000),
    .PROT_LIMIT(PROT_LIMIT),
    .MAILBOX_ADDR(MBOX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_width(req_width),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .lock_set(lock_set),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .locked(locked),
    .mailbox(mailbox)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_access(input logic wr, input logic [2:0] w, input logic [31:0] a,
                              input logic [31:0] d);
    int unsigned sz;
    logic [31:0] v;
    logic [31:0] base;
    bit bad;
    sz  = (w[1:0] == 2'd0) ? 1 : (w[1:0] == 2'd1) ? 2 : 4;
    bad = (w == 3'd3) || (w >= 3'd6) || ((a / 4) >= DEPTH) || ((a % sz) != 0) ||
          (wr && w >= 3'd4) || (wr && m_locked && a < PROT_LIMIT);
    m_fault = bad;
    if (!bad) begin
      if (wr) begin
        for (int i = 0; i < int'(sz); i++) mb[a + i] = d[8*i +: 8];
        if ((a / 4) == (MBOX / 4)) begin
          base = a & ~32'd3;
          m_mailbox = {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
        end
      end else begin
        v = '0;
        for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mb[a + i];
        if (w == 3'd0) v = {{24{v[7]}}, v[7:0]};
        else if (w == 3'd1) v = {{16{v[15]}}, v[15:0]};
        m_rdata = v;
      end
    end
  endtask

  // Reference model: advances on each clock edge, cleared asynchronously by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_init_left = DEPTH;
      m_locked    = 1'b0;
      m_valid     = 1'b0;
      m_fault     = 1'b0;
      m_rdata     = '0;
      m_mailbox   = '0;
      for (int i = 0; i < 4 * DEPTH; i++) mb[i] = 8'h00;
    end else begin
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_rdata = '0;
      if (m_init_left > 0) m_init_left--;
      else if (req_valid) begin
        m_valid = 1'b1;
        model_access(req_write, req_width, req_addr, req_wdata);
      end
      if (lock_set) m_locked = 1'b1;
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(m_init_left == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("locked", 32'(locked), 32'(m_locked));
      chk("mailbox", mailbox, m_mailbox);
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic f,
                        output logic v);
    req_valid = 1'b1;
    req_write = wr;
    req_width = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    v = rsp_valid;
    rd = rsp_rdata;
    f = rsp_fault;
    req_valid = 1'b0;
    lock_set  = 1'b0;
  endtask

  task automatic req_chk(input string name, input logic wr, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_f);
    logic [31:0] rd;
    logic f, v;
    do_req(wr, w, a, d, rd, f, v);
    chk({name, "_valid"}, 32'(v), 32'd1);
    chk({name, "_fault"}, 32'(f), 32'(exp_f));
    chk({name, "_rdata"}, rd, exp_rd);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!req_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_len", 32'(n), 32'd256);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [2:0] wtab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd1, 3'd3, 3'd6};

  initial begin
    logic [31:0] dat [4];
    logic [31:0] rd, a;
    logic f, v;
    int pulses;
    int unsigned r, sz;

    #2;
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_mailbox", mailbox, 32'd0);
    wait_init();

    for (int i = 0; i < int'(DEPTH); i++)
      req_chk("lw_zero", 1'b0, 3'd2, 32'(i * 4), 32'd0, 32'd0, 1'b0);

    req_chk("sw_beef", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    req_chk("lb_13", 1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0);
    req_chk("lhu_12", 1'b0, 3'd5, 32'h12, 32'd0, 32'h0000_DEAD, 1'b0);
    req_chk("sb_11", 1'b1, 3'd0, 32'h11, 32'h55, 32'd0, 1'b0);
    req_chk("lw_10", 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEAD_55EF, 1'b0);

    // store in the same cycle lock_set rises still succeeds
    lock_set = 1'b1;
    req_chk("sw_mbox", 1'b1, 3'd2, 32'h64, 32'h1234, 32'd0, 1'b0);
    chk("mailbox_set", mailbox, 32'h0000_1234);
    chk("lock_now", 32'(locked), 32'd1);
    req_chk("sw_mbox_locked", 1'b1, 3'd2, 32'h64, 32'h9, 32'd0, 1'b1);
    chk("mailbox_kept", mailbox, 32'h0000_1234);
    req_chk("lw_mbox", 1'b0, 3'd2, 32'h64, 32'd0, 32'h0000_1234, 1'b0);
    req_chk("sw_limit", 1'b1, 3'd2, 32'h80, 32'hA5A5_0001, 32'd0, 1'b0);
    req_chk("lw_limit", 1'b0, 3'd2, 32'h80, 32'd0, 32'hA5A5_0001, 1'b0);
    req_chk("lw_40", 1'b0, 3'd2, 32'h40, 32'd0, 32'd0, 1'b0);

    req_chk("lh_mis", 1'b0, 3'd1, 32'h01, 32'd0, 32'd0, 1'b1);
    req_chk("sw_mis", 1'b1, 3'd2, 32'h02, 32'h1, 32'd0, 1'b1);
    req_chk("lw_oob", 1'b0, 3'd2, 32'h400, 32'd0, 32'd0, 1'b1);
    req_chk("w011", 1'b0, 3'd3, 32'h200, 32'd0, 32'd0, 1'b1);
    req_chk("sub", 1'b1, 3'd4, 32'h200, 32'h7, 32'd0, 1'b1);

    // reset mid-INIT unlocks and restarts the clear sweep
    pulse_reset();
    repeat (50) @(posedge clk);
    #1;
    lock_set = 1'b1;
    @(posedge clk);
    #1;
    lock_set = 1'b0;
    chk("init_lock", 32'(locked), 32'd1);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midinit_unlock", 32'(locked), 32'd0);
    chk("midinit_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init();
    req_chk("lw_10_cleared", 1'b0, 3'd2, 32'h10, 32'd0, 32'd0, 1'b0);

    // alternating store/load, valid held for 8 cycles
    pulses = 0;
    for (int k = 0; k < 4; k++) dat[k] = $urandom;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        do_req(1'b1, 3'd2, 32'h200, dat[k/2], rd, f, v);
        chk("alt_sw_fault", 32'(f), 32'd0);
      end else begin
        do_req(1'b0, 3'd2, 32'h200, 32'd0, rd, f, v);
        chk("alt_lw_rdata", rd, dat[k/2]);
      end
      if (v) pulses++;
    end
    chk("alt_pulses", 32'(pulses), 32'd8);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_width = wtab[$urandom_range(0, 9)];
      req_wdata = $urandom;
      lock_set  = ($urandom_range(0, 399) == 0);
      r = $urandom_range(0, 15);
      if (r == 0) a = 32'h400 + 32'($urandom_range(0, 63));
      else if (r == 1) a = 32'hFFFF_FFFC;
      else if (r < 8) a = 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 1023));
      sz = (req_width[1:0] == 2'd0) ? 1 : (req_width[1:0] == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      req_addr = a;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    lock_set  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
